// File: rtl/cache_assoc_fsm_if.sv
// Bundled requester, cache-array and memory signals of the 2-way cache controller.
// The slave modport is the controller's view; the master modport is the environment's view.
interface cache_assoc_fsm_if #(
  parameter int INDEX_W    = 8,
  parameter int WORDS_LOG2 = 2
);
  localparam int TAG_W = 15 - INDEX_W - WORDS_LOG2;

  logic [15:0]           addr;
  logic [15:0]           data_in;
  logic                  read;
  logic                  write;
  logic [15:0]           fs_data_out;
  logic                  fs_done;
  logic                  fs_cachehit;

  logic [1:0]            fc_enable;
  logic [TAG_W-1:0]      fc_tag_in;
  logic [INDEX_W-1:0]    fc_index;
  logic [WORDS_LOG2:0]   fc_offset;
  logic [15:0]           fc_data_in;
  logic                  fc_comp;
  logic                  fc_write;
  logic                  fc_valid_in;
  logic [1:0]            c_hit;
  logic [1:0]            c_dirty;
  logic [1:0]            c_valid;
  logic [2*TAG_W-1:0]    c_tag_out;
  logic [31:0]           c_data_out;

  logic [15:0]           fm_addr;
  logic [15:0]           fm_data_in;
  logic                  fm_wr;
  logic                  fm_rd;
  logic [15:0]           m_data_out;
  logic                  m_stall;

  modport slave (
    input  addr, data_in, read, write,
    output fs_data_out, fs_done, fs_cachehit,
    output fc_enable, fc_tag_in, fc_index, fc_offset, fc_data_in, fc_comp, fc_write, fc_valid_in,
    input  c_hit, c_dirty, c_valid, c_tag_out, c_data_out,
    output fm_addr, fm_data_in, fm_wr, fm_rd,
    input  m_data_out, m_stall
  );

  modport master (
    output addr, data_in, read, write,
    input  fs_data_out, fs_done, fs_cachehit,
    input  fc_enable, fc_tag_in, fc_index, fc_offset, fc_data_in, fc_comp, fc_write, fc_valid_in,
    output c_hit, c_dirty, c_valid, c_tag_out, c_data_out,
    input  fm_addr, fm_data_in, fm_wr, fm_rd,
    output m_data_out, m_stall
  );
endinterface

// File: rtl/cache_assoc_fsm.sv
// 2-way set-associative write-back cache controller: compare, evict dirty victim, fill line.
// Macro CACHE_ASSOC_FSM_LRU_EN selects per-set LRU; without it a global toggle flop picks the victim.
module cache_assoc_fsm #(
  parameter int INDEX_W    = 8,
  parameter int WORDS_LOG2 = 2,
  parameter int MEM_LAT    = 4
) (
  input logic              clk,
  input logic              rst,
  cache_assoc_fsm_if.slave bus
);
  localparam int TAG_W = 15 - INDEX_W - WORDS_LOG2;
  localparam logic [WORDS_LOG2-1:0] LAST_WORD = {WORDS_LOG2{1'b1}};

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COMPARE    = 3'd1,
    EVICT      = 3'd2,
    FILL_ISSUE = 3'd3,
    FILL_WAIT  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [INDEX_W-1:0]    index_q, index_d;
  logic [WORDS_LOG2-1:0] word_q, word_d;
  logic [WORDS_LOG2-1:0] cnt_q, cnt_d;
  logic [WORDS_LOG2-1:0] ret_q, ret_d;
  logic [15:0]           data_q, data_d;
  logic                  write_q, write_d;
  logic                  victim_q, victim_d;
  logic                  filled_q, filled_d;
  logic [MEM_LAT-1:0]    pipe_q, pipe_d;
`ifdef CACHE_ASSOC_FSM_LRU_EN
  logic [(2**INDEX_W)-1:0] lru_q, lru_d;
`else
  logic                  flip_q, flip_d;
`endif

  logic                  hit_way_s;
  logic                  repl_way_s;
  logic                  vic_s;
  logic                  ret_v_s;
  logic                  last_ret_s;
  logic                  issue_s;
  logic [TAG_W-1:0]      vic_tag_s;
  logic                  addr_unused_s;

  assign addr_unused_s = bus.addr[0];
  assign hit_way_s     = ~bus.c_hit[0];
`ifdef CACHE_ASSOC_FSM_LRU_EN
  assign repl_way_s    = lru_q[index_q];
`else
  assign repl_way_s    = flip_q;
`endif
  // Prefer an empty way; only fall back to the replacement policy when both are valid.
  assign vic_s         = !bus.c_valid[0] ? 1'b0 : (!bus.c_valid[1] ? 1'b1 : repl_way_s);
  assign vic_tag_s     = victim_q ? bus.c_tag_out[2*TAG_W-1:TAG_W] : bus.c_tag_out[TAG_W-1:0];
  assign ret_v_s       = pipe_q[MEM_LAT-1];
  assign last_ret_s    = ret_v_s && (ret_q == LAST_WORD);

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    index_d  = index_q;
    word_d   = word_q;
    data_d   = data_q;
    write_d  = write_q;
    victim_d = victim_q;
    filled_d = filled_q;
    cnt_d    = cnt_q;
    ret_d    = ret_q;
    issue_s  = 1'b0;
`ifdef CACHE_ASSOC_FSM_LRU_EN
    lru_d    = lru_q;
`else
    flip_d   = flip_q;
`endif
    bus.fs_data_out = 16'h0000;
    bus.fs_done     = 1'b0;
    bus.fs_cachehit = 1'b0;
    bus.fc_enable   = 2'b00;
    bus.fc_tag_in   = '0;
    bus.fc_index    = '0;
    bus.fc_offset   = '0;
    bus.fc_data_in  = 16'h0000;
    bus.fc_comp     = 1'b0;
    bus.fc_write    = 1'b0;
    bus.fc_valid_in = 1'b0;
    bus.fm_addr     = 16'h0000;
    bus.fm_data_in  = 16'h0000;
    bus.fm_wr       = 1'b0;
    bus.fm_rd       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.read || bus.write) begin
          tag_d    = bus.addr[15 -: TAG_W];
          index_d  = bus.addr[WORDS_LOG2+1 +: INDEX_W];
          word_d   = bus.addr[1 +: WORDS_LOG2];
          data_d   = bus.data_in;
          write_d  = bus.write;
          filled_d = 1'b0;
          state_d  = COMPARE;
        end else begin
          state_d  = IDLE;
        end
      end
      COMPARE: begin
        bus.fc_enable  = 2'b11;
        bus.fc_comp    = 1'b1;
        bus.fc_write   = write_q;
        bus.fc_tag_in  = tag_q;
        bus.fc_index   = index_q;
        bus.fc_offset  = {word_q, 1'b0};
        bus.fc_data_in = data_q;
        if (|bus.c_hit) begin
          bus.fs_done     = 1'b1;
          bus.fs_cachehit = ~filled_q;
          bus.fs_data_out = hit_way_s ? bus.c_data_out[31:16] : bus.c_data_out[15:0];
`ifdef CACHE_ASSOC_FSM_LRU_EN
          lru_d[index_q]  = ~hit_way_s;
`endif
          state_d         = IDLE;
        end else begin
          victim_d = vic_s;
`ifndef CACHE_ASSOC_FSM_LRU_EN
          flip_d   = (&bus.c_valid) ? ~flip_q : flip_q;
`endif
          state_d  = (bus.c_valid[vic_s] && bus.c_dirty[vic_s]) ? EVICT : FILL_ISSUE;
        end
      end
      EVICT: begin
        bus.fc_enable  = {victim_q, ~victim_q};
        bus.fc_index   = index_q;
        bus.fc_offset  = {cnt_q, 1'b0};
        bus.fm_addr    = {vic_tag_s, index_q, cnt_q, 1'b0};
        bus.fm_data_in = victim_q ? bus.c_data_out[31:16] : bus.c_data_out[15:0];
        if (!bus.m_stall) begin
          bus.fm_wr = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          state_d   = (cnt_q == LAST_WORD) ? FILL_ISSUE : EVICT;
        end else begin
          cnt_d     = cnt_q;
        end
      end
      FILL_ISSUE: begin
        bus.fm_addr = {tag_q, index_q, cnt_q, 1'b0};
        if (!bus.m_stall) begin
          bus.fm_rd = 1'b1;
          issue_s   = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          state_d   = (cnt_q == LAST_WORD) ? FILL_WAIT : FILL_ISSUE;
        end else begin
          cnt_d     = cnt_q;
        end
      end
      FILL_WAIT: begin
        if (last_ret_s) begin
          filled_d = 1'b1;
          state_d  = COMPARE;
        end else begin
          state_d  = FILL_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Returned words land in the victim way on their arrival cycle, in issue order.
    if (ret_v_s && (state_q == FILL_ISSUE || state_q == FILL_WAIT)) begin
      bus.fc_enable   = {victim_q, ~victim_q};
      bus.fc_write    = 1'b1;
      bus.fc_tag_in   = tag_q;
      bus.fc_index    = index_q;
      bus.fc_offset   = {ret_q, 1'b0};
      bus.fc_data_in  = bus.m_data_out;
      bus.fc_valid_in = last_ret_s;
      ret_d           = ret_q + 1'b1;
    end else begin
      ret_d           = ret_q;
    end

    pipe_d[0] = issue_s;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // State and tracker registers; reset discards any in-flight returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      index_q  <= '0;
      word_q   <= '0;
      data_q   <= 16'h0000;
      write_q  <= 1'b0;
      victim_q <= 1'b0;
      filled_q <= 1'b0;
      cnt_q    <= '0;
      ret_q    <= '0;
      pipe_q   <= '0;
`ifdef CACHE_ASSOC_FSM_LRU_EN
      lru_q    <= '0;
`else
      flip_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
      word_q   <= word_d;
      data_q   <= data_d;
      write_q  <= write_d;
      victim_q <= victim_d;
      filled_q <= filled_d;
      cnt_q    <= cnt_d;
      ret_q    <= ret_d;
      pipe_q   <= pipe_d;
`ifdef CACHE_ASSOC_FSM_LRU_EN
      lru_q    <= lru_d;
`else
      flip_q   <= flip_d;
`endif
    end
  end
endmodule

// File: tb/tb_cache_assoc_fsm.sv
// Directed bench for cache_assoc_fsm with a behavioural 2-way cache array and fixed-latency memory.
module tb_cache_assoc_fsm;
  localparam int INDEX_W    = 8;
  localparam int WORDS_LOG2 = 2;
  localparam int MEM_LAT    = 4;
  localparam int TAG_W      = 5;

  logic clk;
  logic rst;
  cache_assoc_fsm_if #(.INDEX_W(INDEX_W), .WORDS_LOG2(WORDS_LOG2)) bus ();
  cache_assoc_fsm #(.INDEX_W(INDEX_W), .WORDS_LOG2(WORDS_LOG2), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int failures;

  always #5 clk = ~clk;

  // Cache array model.
  logic [TAG_W-1:0] mt   [2][256];
  logic             mv   [2][256];
  logic             md   [2][256];
  logic [15:0]      mdat [2][256][4];
  logic             pl_clr, pl_en, pl_w, pl_d;
  logic [7:0]       pl_i;
  logic [TAG_W-1:0] pl_tag;
  logic [15:0]      pl_base;

  always_comb begin
    bus.c_valid    = 2'b00;
    bus.c_dirty    = 2'b00;
    bus.c_hit      = 2'b00;
    bus.c_tag_out  = '0;
    bus.c_data_out = 32'h0;
    for (int w = 0; w < 2; w++) begin
      bus.c_valid[w]             = mv[w][bus.fc_index];
      bus.c_dirty[w]             = md[w][bus.fc_index];
      bus.c_tag_out[w*TAG_W +: TAG_W] = mt[w][bus.fc_index];
      bus.c_data_out[w*16 +: 16] = mdat[w][bus.fc_index][bus.fc_offset[2:1]];
      bus.c_hit[w]               = bus.fc_comp && bus.fc_enable[w] && mv[w][bus.fc_index]
                                   && (mt[w][bus.fc_index] == bus.fc_tag_in);
    end
  end

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < 256; i++) begin
          mv[w][i] <= 1'b0;
          md[w][i] <= 1'b0;
        end
    end else if (pl_en) begin
      mt[pl_w][pl_i] <= pl_tag;
      mv[pl_w][pl_i] <= 1'b1;
      md[pl_w][pl_i] <= pl_d;
      for (int k = 0; k < 4; k++) mdat[pl_w][pl_i][k] <= pl_base + 16'(k);
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (bus.fc_write && bus.fc_enable[w]) begin
          if (bus.fc_comp) begin
            if (bus.c_hit[w]) begin
              mdat[w][bus.fc_index][bus.fc_offset[2:1]] <= bus.fc_data_in;
              md[w][bus.fc_index] <= 1'b1;
            end
          end else begin
            mdat[w][bus.fc_index][bus.fc_offset[2:1]] <= bus.fc_data_in;
            mt[w][bus.fc_index] <= bus.fc_tag_in;
            mv[w][bus.fc_index] <= bus.fc_valid_in;
            md[w][bus.fc_index] <= 1'b0;
          end
        end
      end
    end
  end

  // Memory model: read data = address ^ 16'hA5A5, MEM_LAT cycles after the strobe cycle.
  logic [15:0] mp_a [MEM_LAT];
  always @(posedge clk) begin
    mp_a[0] <= bus.fm_addr;
    for (int i = 1; i < MEM_LAT; i++) mp_a[i] <= mp_a[i-1];
  end
  assign bus.m_data_out = mp_a[MEM_LAT-1] ^ 16'hA5A5;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic w, input logic [7:0] idx, input logic [TAG_W-1:0] t,
                         input logic dty, input logic [15:0] base);
    pl_w = w; pl_i = idx; pl_tag = t; pl_d = dty; pl_base = base; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  int          done_cyc, fillw_last, wr_n;
  logic        hit_o;
  logic [15:0] dout;
  logic [31:0] rd_mask, wr_mask;
  logic [15:0] wr_addr [4];
  logic [15:0] wr_data [4];

  // Issue one request; cycle 0 is the accept cycle. Stall m_stall for cycles [st_s, st_s+st_l).
  task automatic run_req(input logic [15:0] a, input logic [15:0] d, input logic w,
                         input int st_s, input int st_l);
    bus.addr = a; bus.data_in = d; bus.write = w; bus.read = ~w;
    @(posedge clk); #1;
    bus.read = 1'b0; bus.write = 1'b0;
    done_cyc = -1; fillw_last = -1; wr_n = 0; rd_mask = 32'h0; wr_mask = 32'h0;
    hit_o = 1'b0; dout = 16'h0;
    for (int c = 1; c < 30 && done_cyc < 0; c++) begin
      bus.m_stall = (c >= st_s) && (c < st_s + st_l);
      #1;
      if (bus.fm_rd) rd_mask[c] = 1'b1;
      if (bus.fm_wr) begin
        wr_mask[c] = 1'b1;
        if (wr_n < 4) begin
          wr_addr[wr_n] = bus.fm_addr;
          wr_data[wr_n] = bus.fm_data_in;
        end
        wr_n++;
      end
      if (bus.fc_write && !bus.fc_comp) fillw_last = c;
      if (bus.fs_done) begin
        done_cyc = c; hit_o = bus.fs_cachehit; dout = bus.fs_data_out;
      end
      @(posedge clk); #1;
    end
    bus.m_stall = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          fw_cnt;
    logic [4:0]  exp_t0, exp_t1;
    checks = 0; failures = 0;
    clk = 1'b0; rst = 1'b0;
    bus.addr = 16'h0; bus.data_in = 16'h0; bus.read = 1'b0; bus.write = 1'b0; bus.m_stall = 1'b0;
    pl_en = 1'b0; pl_w = 1'b0; pl_i = 8'h0; pl_tag = '0; pl_d = 1'b0; pl_base = 16'h0;
    pl_clr = 1'b1;
    @(posedge clk); #1;
    pl_clr = 1'b0;
    check_val("rst_strobes", {bus.fs_done, bus.fs_cachehit, bus.fm_rd, bus.fm_wr, bus.fc_write,
                              bus.fc_comp, bus.fc_valid_in, bus.fc_enable}, 32'h0);
    check_val("rst_fm_addr", bus.fm_addr, 32'h0);
    check_val("rst_fs_data", bus.fs_data_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Read hit in way 1: addr 0x1234 -> tag 2, index 0x46, word 2.
    preload(1'b1, 8'h46, 5'd2, 1'b0, 16'hBE00);
    run_req(16'h1234, 16'h0, 1'b0, 0, 0);
    check_val("hit_done_cyc", done_cyc, 32'd1);
    check_val("hit_cachehit", hit_o, 32'd1);
    check_val("hit_data", dout, 32'hBE02);

    // Write hit on the same word marks the line dirty.
    run_req(16'h1234, 16'h5555, 1'b1, 0, 0);
    check_val("whit_done_cyc", done_cyc, 32'd1);
    check_val("whit_cachehit", hit_o, 32'd1);
    check_val("whit_data", mdat[1][8'h46][2], 32'h5555);
    check_val("whit_dirty", md[1][8'h46], 32'd1);

    // Clean miss into an empty set: addr 0x0840 -> tag 1, index 8.
    run_req(16'h0840, 16'h0, 1'b0, 0, 0);
    check_val("cmiss_rd_cycles", rd_mask, 32'h0000_003C);
    check_val("cmiss_last_fill", fillw_last, 32'd9);
    check_val("cmiss_done_cyc", done_cyc, 32'd10);
    check_val("cmiss_cachehit", hit_o, 32'd0);
    check_val("cmiss_data", dout, 32'hADE5);
    check_val("cmiss_way0_tag", {mv[0][8], mt[0][8]}, 32'h21);

    // Dirty miss: way 0 holds tag 0x1A dirty at index 3; request tag 7 word 1.
    preload(1'b0, 8'h03, 5'h1A, 1'b1, 16'h1000);
    preload(1'b1, 8'h03, 5'h05, 1'b0, 16'h2000);
    run_req(16'h381A, 16'h0, 1'b0, 0, 0);
    check_val("dmiss_wr_cycles", wr_mask, 32'h0000_003C);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("dmiss_wr_addr%0d", k), wr_addr[k], 32'hD018 + 32'(2 * k));
      check_val($sformatf("dmiss_wr_data%0d", k), wr_data[k], 32'h1000 + 32'(k));
    end
    check_val("dmiss_rd_cycles", rd_mask, 32'h0000_03C0);
    check_val("dmiss_done_cyc", done_cyc, 32'd14);
    check_val("dmiss_data", dout, 32'h9DBF);
    check_val("dmiss_way0_tag", mt[0][3], 32'd7);

    // Replacement: index 5, way 0 tag 3, way 1 tag 4, both clean.
    preload(1'b0, 8'h05, 5'd3, 1'b0, 16'h3000);
    preload(1'b1, 8'h05, 5'd4, 1'b0, 16'h4000);
    run_req(16'h1828, 16'h0, 1'b0, 0, 0);
    check_val("repl_hit0_data", dout, 32'h3000);
    check_val("repl_hit0_cachehit", hit_o, 32'd1);
    run_req(16'h3028, 16'h0, 1'b0, 0, 0);
    check_val("repl_miss1_done_cyc", done_cyc, 32'd10);
    check_val("repl_miss1_tags", {mt[1][5], mt[0][5]}, {22'h0, 5'd6, 5'd3});
    run_req(16'h1828, 16'h0, 1'b0, 0, 0);
    check_val("repl_hit0b_cachehit", hit_o, 32'd1);
    run_req(16'h3828, 16'h0, 1'b0, 0, 0);
`ifdef CACHE_ASSOC_FSM_LRU_EN
    exp_t0 = 5'd3; exp_t1 = 5'd7;
`else
    exp_t0 = 5'd7; exp_t1 = 5'd6;
`endif
    check_val("repl_miss2_tags", {mt[1][5], mt[0][5]}, {22'h0, exp_t1, exp_t0});

    // Stall for cycles 3..5 during fill issue: addr 0x0880 -> index 0x10.
    run_req(16'h0880, 16'h0, 1'b0, 3, 3);
    check_val("stall_rd_cycles", rd_mask, 32'h0000_01C4);
    check_val("stall_done_cyc", done_cyc, 32'd13);
    check_val("stall_data", dout, 32'hAD25);

    // Reset during the second fill issue: addr 0x1100 -> tag 2, index 0x20.
    bus.addr = 16'h1100; bus.read = 1'b1;
    @(posedge clk); #1;
    bus.read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rstmid_pre_rd", bus.fm_rd, 32'd1);
    rst = 1'b0;
    #1;
    check_val("rstmid_strobes", {bus.fs_done, bus.fm_rd, bus.fm_wr, bus.fc_write,
                                 bus.fc_comp, bus.fc_enable}, 32'h0);
    check_val("rstmid_fm_addr", bus.fm_addr, 32'h0);
    fw_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) rst = 1'b1;
      #1;
      if (bus.fc_write) fw_cnt++;
    end
    check_val("rstmid_no_fill_write", fw_cnt, 32'd0);
    check_val("rstmid_set_invalid", {mv[1][8'h20], mv[0][8'h20]}, 32'h0);
    @(posedge clk); #1;
    run_req(16'h1100, 16'h0, 1'b0, 0, 0);
    check_val("rstmid_next_done_cyc", done_cyc, 32'd10);
    check_val("rstmid_next_data", dout, 32'hB4A5);
    check_val("rstmid_next_cachehit", hit_o, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_assoc_fsm.md
CACHE_ASSOC_FSM -- requirements
Module: cache_assoc_fsm

Interface
REQ-001 Parameter INDEX_W, default 8, set-index width; TAG_W = 15-INDEX_W-WORDS_LOG2 (5 at defaults).
REQ-002 Parameter WORDS_LOG2, default 2, log2 of 16-bit words per line.
REQ-003 Parameter MEM_LAT, default 4, memory read latency in cycles (range 1..8).
REQ-004 The clock and reset ports SHALL be as follows.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
REQ-005 The requester-side ports SHALL be as follows.
- addr  in  16  byte address; bit 0 ignored.
- data_in  in  16  write data.
- read  in  1  read request.
- write  in  1  write request.
- fs_data_out  out  16  read data, valid with fs_done.
- fs_done  out  1  one-cycle completion pulse.
- fs_cachehit  out  1  high with fs_done when the request hit on its first compare.
REQ-006 The cache-array ports SHALL be as follows.
- fc_enable  out  2  per-way enable.
- fc_tag_in  out  TAG_W  tag to compare or write.
- fc_index  out  INDEX_W  set index.
- fc_offset  out  WORDS_LOG2+1  byte offset within the line; bit 0 always 0.
- fc_data_in  out  16  cache write data.
- fc_comp  out  1  compare mode.
- fc_write  out  1  write strobe.
- fc_valid_in  out  1  valid bit to write.
- c_hit  in  2  per-way hit.
- c_dirty  in  2  per-way dirty.
- c_valid  in  2  per-way valid.
- c_tag_out  in  2*TAG_W  per-way stored tag; way 0 in the low bits.
- c_data_out  in  32  per-way data; way 0 in the low bits.
REQ-007 The memory ports SHALL be as follows.
- fm_addr  out  16  memory byte address.
- fm_data_in  out  16  write-back data.
- fm_wr  out  1  memory write strobe.
- fm_rd  out  1  memory read strobe.
- m_data_out  in  16  read data, valid exactly MEM_LAT cycles after the fm_rd cycle.
- m_stall  in  1  memory cannot accept a strobe this cycle.

Function
REQ-010 The FSM SHALL have the states IDLE, COMPARE, EVICT, FILL_ISSUE, FILL_WAIT.
- IDLE: latch addr, data_in and write on (read|write), then go to COMPARE.
- read&write together is treated as a write.
- Requests arriving outside IDLE are ignored.
REQ-011 In COMPARE, the FSM SHALL drive fc_enable=2'b11, fc_comp=1 and fc_write=latched write.
- A hit completes in that same cycle: fs_done=1, fs_data_out = hit way's word, return to IDLE.
- Hit latency is 1 cycle after the accept cycle.
- If both c_hit bits are set, way 0 is used.
REQ-012 Victim selection on a miss SHALL be:
- first, the lowest-numbered way with c_valid=0;
- otherwise, the way chosen per REQ-030.
REQ-013 EVICT SHALL apply when the victim is valid and dirty.
- Issue 2^WORDS_LOG2 fm_wr strobes, word 0 first.
- fm_addr = {victim tag, index, word, 1'b0}.
- fm_data_in = victim c_data_out read with fc_comp=0, fc_write=0.
- While m_stall=1, no strobe is issued and the word counter holds.
REQ-014 FILL_ISSUE SHALL issue one fm_rd per non-stalled cycle, word 0 first.
- FILL_WAIT follows and lasts until all words have returned.
- Each word is written into the victim way on its return cycle: fc_comp=0, fc_write=1, fc_data_in=m_data_out.
- fc_valid_in=1 is driven with the last word.
- Next state after the last word is COMPARE, which then hits; fs_cachehit=0 for a filled request.
REQ-015 The in-flight return tracker SHALL be a MEM_LAT-deep shift pipe.
- m_stall does not affect returns already in flight.
REQ-016 Idle defaults SHALL apply: fc_*/fm_* strobes are 0 in any cycle not stated above, and fs_done is never high two cycles in a row.

Reset
REQ-020 While rst=0, the block SHALL hold:
- state = IDLE; all outputs 0; replacement state and in-flight tracker cleared.
- In-flight memory returns are discarded, including when reset is asserted mid-EVICT or mid-FILL.
- Operation resumes on the first clk edge after rst rises.

Configuration
REQ-030 Macro CACHE_ASSOC_FSM_LRU_EN SHALL select the replacement policy.
- Defined: one LRU bit per set, set to the non-hit way on every COMPARE hit; the victim is the LRU way.
- Undefined: no per-set state; one global flip-flop toggles on every miss-with-both-ways-valid, and its pre-toggle value picks the victim.

Verification (defaults, LRU_EN defined)
REQ-040 Read hit in way 1 at addr 0x1234 -> fs_done and fs_cachehit high 1 cycle after accept, fs_data_out = way-1 word.
REQ-041 Clean read miss, m_stall=0 -> 4 fm_rd strobes on cycles 2-5; last fill write on cycle 9; fs_done on cycle 10 with fs_cachehit=0.
REQ-042 Dirty miss, victim tag 0x1A, index 0x03 -> fm_wr addresses 0xD018, 0xD01A, 0xD01C, 0xD01E on cycles 2-5; fs_done on cycle 14.
REQ-043 Both ways valid, hit way 0 then miss same set -> way 1 evicted/filled; with macro undefined, victim follows the toggle flip-flop.
REQ-044 m_stall=1 for 3 cycles during FILL_ISSUE -> no fm_rd during the stall; fs_done delayed by exactly 3 cycles.
REQ-045 rst low in the cycle of the second fill issue -> outputs 0 immediately; late m_data_out does not write the cache; next request is serviced normally.
